// File: rtl/prng_pkg.sv
// Shared constants and types for the pseudo-random stream generator.
//   XOR_MASK_16 / AND_MASK_16 / INIT_16 : defaults for the 16-bit configuration
//   mode_e                               : feedback mode select
//   cnt_width()                          : collector counter width for a word size
package prng_pkg;

  localparam logic [15:0] XOR_MASK_16 = 16'h8101;
  localparam logic [15:0] AND_MASK_16 = 16'h020E;
  localparam logic [15:0] INIT_16     = 16'h0001;

  typedef enum logic {
    MODE_LFSR  = 1'b0,
    MODE_NLFSR = 1'b1
  } mode_e;

  // At least one bit so a 1-bit word still has a legal counter.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prng_core.sv
// Shift-register core: state register, LFSR/NLFSR feedback, seed load and
// all-zero lockup recovery.
//   clk, rst_n  : clock, async active-low reset
//   step        : request one shift this cycle
//   mode        : feedback mode (AND term only in MODE_NLFSR)
//   seed_valid  : load seed_data (wins over step)
//   seed_data   : seed value; zero is replaced by INIT
//   state       : current register contents
//   lockup      : sticky flag, set when INIT replaced a zero state/seed
//   stepped_c   : a shift happens on this edge (state[0] is being emitted)
module prng_core
  import prng_pkg::*;
#(
  parameter int unsigned       WIDTH    = 16,
  parameter logic [WIDTH-1:0]  XOR_MASK = WIDTH'(XOR_MASK_16),
  parameter logic [WIDTH-1:0]  AND_MASK = WIDTH'(AND_MASK_16),
  parameter logic [WIDTH-1:0]  INIT     = WIDTH'(INIT_16)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,
  input  mode_e            mode,
  input  logic             seed_valid,
  input  logic [WIDTH-1:0] seed_data,
  output logic [WIDTH-1:0] state,
  output logic             lockup,
  output logic             stepped_c
);

  localparam bit HAS_AND = (AND_MASK != '0);

  logic             and_term_c;
  logic             fb_c;
  logic             zero_state_c;
  logic [WIDTH-1:0] state_nxt;
  logic             lockup_nxt;

  // Feedback: parity of tapped bits, plus AND of masked bits in NLFSR mode.
  always_comb begin
    and_term_c = 1'b0;
    if (HAS_AND) and_term_c = &(state | ~AND_MASK);
    fb_c = (^(state & XOR_MASK)) ^ ((mode == MODE_NLFSR) && and_term_c);
  end

  assign zero_state_c = (state == '0);
  assign stepped_c    = step && !seed_valid && !zero_state_c;

  // Next state: seed first, then lockup recovery, then a normal shift.
  always_comb begin
    state_nxt  = state;
    lockup_nxt = lockup;
    if (seed_valid) begin
      if (seed_data == '0) begin
        state_nxt  = INIT;
        lockup_nxt = 1'b1;
      end else begin
        state_nxt  = seed_data;
        lockup_nxt = 1'b0;
      end
    end else if (zero_state_c) begin
      state_nxt  = INIT;
      lockup_nxt = 1'b1;
    end else if (step) begin
      state_nxt = {fb_c, state[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= INIT;
      lockup <= 1'b0;
    end else begin
      state  <= state_nxt;
      lockup <= lockup_nxt;
    end
  end

endmodule

// File: rtl/prng_stream_gen.sv
// Pseudo-random stream generator: prng_core plus a serial-to-word collector
// with a valid/ready output stream and backpressure.
//   clk, rst_n   : clock, async active-low reset
//   en           : advance one step per cycle unless stalled
//   mode         : 0 = linear LFSR, 1 = NLFSR
//   seed_valid   : seed load request; seed_data is the value
//   seed_ready   : always 1
//   serial_out   : current state[0]
//   out_valid    : out_data holds an unconsumed word
//   out_ready    : consumer accepts the word
//   out_data     : collected word, first-emitted bit in LSB
//   lockup       : sticky zero-state / zero-seed recovery flag
module prng_stream_gen
  import prng_pkg::*;
#(
  parameter int unsigned       WIDTH    = 16,
  parameter logic [WIDTH-1:0]  XOR_MASK = WIDTH'(XOR_MASK_16),
  parameter logic [WIDTH-1:0]  AND_MASK = WIDTH'(AND_MASK_16),
  parameter logic [WIDTH-1:0]  INIT     = WIDTH'(INIT_16),
  parameter int unsigned       OUT_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                mode,
  input  logic                seed_valid,
  input  logic [WIDTH-1:0]    seed_data,
  output logic                seed_ready,
  output logic                serial_out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_BITS-1:0] out_data,
  output logic                lockup
);

  localparam int unsigned      CNT_W = cnt_width(OUT_BITS);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(OUT_BITS - 1);

  logic [WIDTH-1:0]    core_state;
  logic                core_stepped_c;
  logic                stall_c;
  logic                step_c;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic [OUT_BITS-1:0] partial;
  logic [OUT_BITS-1:0] partial_nxt;
  logic [OUT_BITS-1:0] word_c;
  logic [OUT_BITS-1:0] out_data_nxt;
  logic                out_valid_nxt;

  // Only a word that would complete into an occupied, unaccepted slot stalls.
  assign stall_c = (cnt == LAST) && out_valid && !out_ready;
  assign step_c  = en && !stall_c;

  prng_core #(
    .WIDTH    (WIDTH),
    .XOR_MASK (XOR_MASK),
    .AND_MASK (AND_MASK),
    .INIT     (INIT)
  ) u_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .step       (step_c),
    .mode       (mode_e'(mode)),
    .seed_valid (seed_valid),
    .seed_data  (seed_data),
    .state      (core_state),
    .lockup     (lockup),
    .stepped_c  (core_stepped_c)
  );

  assign seed_ready = 1'b1;
  assign serial_out = core_state[0];

  // Partial word with the bit being emitted this cycle dropped into slot cnt.
  always_comb begin
    word_c      = partial;
    word_c[cnt] = core_state[0];
  end

  // Collector and output handshake next-state.
  always_comb begin
    cnt_nxt       = cnt;
    partial_nxt   = partial;
    out_data_nxt  = out_data;
    out_valid_nxt = out_valid;
    if (seed_valid) begin
      cnt_nxt       = '0;
      partial_nxt   = '0;
      out_valid_nxt = 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid_nxt = 1'b0;
      if (core_stepped_c) begin
        if (cnt == LAST) begin
          // Completed word overwrites the slot; valid stays/goes high.
          out_data_nxt  = word_c;
          out_valid_nxt = 1'b1;
          cnt_nxt       = '0;
          partial_nxt   = '0;
        end else begin
          partial_nxt = word_c;
          cnt_nxt     = cnt + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      partial   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      partial   <= partial_nxt;
      out_data  <= out_data_nxt;
      out_valid <= out_valid_nxt;
    end
  end

endmodule

// File: tb/tb_prng_stream_gen.sv
// Self-checking bench for prng_stream_gen in its default 16-bit / 8-bit-word
// configuration: directed vectors plus a behavioural reference for long streams.
module tb_prng_stream_gen;

  localparam logic [15:0] XM  = 16'h8101;
  localparam logic [15:0] AM  = 16'h020E;
  localparam logic [15:0] INI = 16'h0001;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        mode;
  logic        seed_valid;
  logic [15:0] seed_data;
  logic        seed_ready;
  logic        serial_out;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        lockup;

  int n_checks = 0;
  int n_errors = 0;

  prng_stream_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .mode       (mode),
    .seed_valid (seed_valid),
    .seed_data  (seed_data),
    .seed_ready (seed_ready),
    .serial_out (serial_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .lockup     (lockup)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference step written bit by bit.
  function automatic logic [15:0] model_next(input logic [15:0] s, input logic m);
    logic lin;
    logic all_set;
    lin     = 1'b0;
    all_set = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (XM[i]) lin = lin ^ s[i];
      if (AM[i] && !s[i]) all_set = 1'b0;
    end
    return {lin ^ (m & all_set), s[15:1]};
  endfunction

  // Seed, then compare the transferred word stream against the reference.
  task automatic run_stream(input logic m, input int nwords);
    logic [15:0] ms;
    logic [7:0]  w;
    logic [7:0]  exp_q[$];
    int          idx;
    int          b;
    bit          rdy;
    ms = 16'hACE1;
    for (int k = 0; k < nwords; k++) begin
      w = '0;
      b = 0;
      while (b < 8) begin
        if (ms == 16'h0000) begin
          ms = INI;
        end else begin
          w[b] = ms[0];
          ms   = model_next(ms, m);
          b++;
        end
      end
      exp_q.push_back(w);
    end
    mode       = m;
    en         = 1'b1;
    out_ready  = 1'b1;
    seed_valid = 1'b1;
    seed_data  = 16'hACE1;
    tick();
    seed_valid = 1'b0;
    idx = 0;
    for (int cyc = 0; cyc < nwords * 40 + 100 && idx < nwords; cyc++) begin
      rdy = ($urandom_range(0, 3) != 0);
      if (out_valid && rdy) begin
        check_eq($sformatf("stream_m%0d_w%0d", m, idx), 64'(out_data), 64'(exp_q[idx]));
        idx++;
      end
      out_ready = rdy;
      tick();
    end
    if (idx < nwords) check_eq("stream_timeout", 64'(idx), 64'(nwords));
  endtask

  initial begin
    rst_n      = 1'b0;
    en         = 1'b0;
    mode       = 1'b1;
    seed_valid = 1'b0;
    seed_data  = 16'h0000;
    out_ready  = 1'b1;
    #12;
    rst_n = 1'b1;

    // Idle after reset.
    check_eq("rst_seed_ready", 64'(seed_ready), 64'd1);
    check_eq("rst_out_data", 64'(out_data), 64'h00);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("idle_state", 64'(dut.core_state), 64'h0001);
      check_eq("idle_serial", 64'(serial_out), 64'd1);
      check_eq("idle_valid", 64'(out_valid), 64'd0);
      check_eq("idle_lockup", 64'(lockup), 64'd0);
    end

    // First word in NLFSR mode.
    en = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    check_eq("w1_not_yet_valid", 64'(out_valid), 64'd0);
    check_eq("w1_state7", 64'(dut.core_state), 64'hFE00);
    tick();
    check_eq("w1_valid", 64'(out_valid), 64'd1);
    check_eq("w1_data", 64'(out_data), 64'h01);
    check_eq("w1_state8", 64'(dut.core_state), 64'hFF00);
    check_eq("bit9_serial", 64'(serial_out), 64'd0);

    // Backpressure: 7 more steps then stall with word 1 held.
    out_ready = 1'b0;
    tick();
    check_eq("state9", 64'(dut.core_state), 64'h7F80);
    check_eq("w1_held_valid", 64'(out_valid), 64'd1);
    for (int i = 0; i < 6; i++) tick();
    check_eq("state15", 64'(dut.core_state), 64'h55FE);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stall_state", 64'(dut.core_state), 64'h55FE);
      check_eq("stall_data", 64'(out_data), 64'h01);
      check_eq("stall_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    tick();
    check_eq("w2_data", 64'(out_data), 64'h00);
    check_eq("w2_valid", 64'(out_valid), 64'd1);
    check_eq("state16", 64'(dut.core_state), 64'hAAFF);
    tick();
    check_eq("w2_consumed", 64'(out_valid), 64'd0);

    // Zero seed -> INIT + lockup; nonzero seed clears it.
    seed_valid = 1'b1;
    seed_data  = 16'h0000;
    tick();
    check_eq("zseed_state", 64'(dut.core_state), 64'h0001);
    check_eq("zseed_lockup", 64'(lockup), 64'd1);
    check_eq("zseed_valid", 64'(out_valid), 64'd0);
    check_eq("zseed_cnt", 64'(dut.cnt), 64'd0);
    seed_valid = 1'b0;
    tick();
    check_eq("lockup_sticky", 64'(lockup), 64'd1);
    check_eq("post_zseed_step", 64'(dut.core_state), 64'h8000);
    seed_valid = 1'b1;
    seed_data  = 16'hACE1;
    tick();
    seed_valid = 1'b0;
    check_eq("seed_lockup_clr", 64'(lockup), 64'd0);
    check_eq("seed_serial", 64'(serial_out), 64'd1);
    check_eq("seed_state", 64'(dut.core_state), 64'hACE1);

    // Long streams from the same seed in both modes.
    run_stream(1'b0, 500);
    run_stream(1'b1, 500);

    // Reset mid-word.
    out_ready = 1'b1;
    en        = 1'b1;
    begin
      int guard;
      guard = 0;
      while (dut.cnt != 3'd4 && guard < 40) begin
        tick();
        guard++;
      end
      check_eq("midword_cnt", 64'(dut.cnt), 64'd4);
    end
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_state", 64'(dut.core_state), 64'h0001);
    check_eq("async_rst_valid", 64'(out_valid), 64'd0);
    tick();
    check_eq("rst_state", 64'(dut.core_state), 64'h0001);
    check_eq("rst_cnt", 64'(dut.cnt), 64'd0);
    check_eq("rst_data", 64'(out_data), 64'h00);
    mode  = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    check_eq("post_rst_valid", 64'(out_valid), 64'd1);
    check_eq("post_rst_word", 64'(out_data), 64'h01);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
